// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: state encoding and shared constants for the UART command frame controller
package uart_cmd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CSUM} state_t;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;
  localparam logic [15:0] DEF_TIMEOUT_CLKS = 16'd50000;
  localparam logic [4:0] DEF_MAX_LEN = 5'd16;
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts idle clocks between bytes, flags expiry when no byte arrives in time
module uart_gap_timer
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [15:0] count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else count <= (clear || !enable) ? '0 : count + 16'd1;
  end
  // a byte arriving on the expiry clock wins
  assign expire = enable && !clear && (count == TIMEOUT_CLKS - 16'd1);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/CMD/LEN/payload/CSUM frames from a UART byte stream,
// streams payload writes speculatively and commits or rejects each frame.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  parameter logic [4:0]  MAX_LEN = DEF_MAX_LEN
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic [3:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd,
  output logic [4:0] o_Cmd_Len,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);
  state_t     state;
  logic [7:0] cmd_r;
  logic [4:0] len_r;
  logic [4:0] idx;
  logic [7:0] acc;
  logic       expire;
  uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap (
    .clk(i_Clock),
    .rst_n(i_Rst_n),
    .clear(i_Rx_DV),
    .enable(state != S_IDLE),
    .expire(expire)
  );
  assign o_Busy = (state != S_IDLE);
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
      cmd_r <= '0;
      len_r <= '0;
      idx <= '0;
      acc <= '0;
      o_Wr_En <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Cmd <= '0;
      o_Cmd_Len <= '0;
      o_Err <= 1'b0;
      o_Err_Code <= '0;
    end else begin
      o_Wr_En <= 1'b0;
      o_Cmd_Valid <= 1'b0;
      o_Err <= 1'b0;
      if (i_Rx_DV) begin
        case (state)
          S_IDLE: state <= (i_Rx_Byte == SYNC) ? S_CMD : S_IDLE;
          S_CMD: begin
            cmd_r <= i_Rx_Byte;
            acc <= i_Rx_Byte;
            state <= S_LEN;
          end
          S_LEN: begin
            acc <= acc + i_Rx_Byte;
            len_r <= i_Rx_Byte[4:0];
            idx <= '0;
            if (i_Rx_Byte > {3'b000, MAX_LEN}) begin
              o_Err <= 1'b1;
              o_Err_Code <= ERR_LEN;
              state <= S_IDLE;
            end else begin
              state <= (i_Rx_Byte == 8'd0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: begin
            o_Wr_En <= 1'b1;
            o_Wr_Addr <= idx[3:0];
            o_Wr_Data <= i_Rx_Byte;
            acc <= acc + i_Rx_Byte;
            idx <= idx + 5'd1;
            state <= (idx == len_r - 5'd1) ? S_CSUM : S_DATA;
          end
          S_CSUM: begin
            if (i_Rx_Byte == acc) begin
              o_Cmd <= cmd_r;
              o_Cmd_Len <= len_r;
              o_Cmd_Valid <= 1'b1;
            end else begin
              o_Err <= 1'b1;
              o_Err_Code <= ERR_CSUM;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (expire) begin
        o_Err <= 1'b1;
        o_Err_Code <= ERR_TIMEOUT;
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed and randomized frame checks against a stream-parsing reference model
module tb_uart_cmd_ctrl;
  typedef logic [7:0] bq_t[$];
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       wr_en, cmd_valid, err, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, cmd;
  logic [4:0] cmd_len;
  logic [1:0] err_code;
  int tests = 0;
  int fails = 0;
  int both_cnt = 0;
  logic [11:0] wr_q[$];
  logic [15:0] ev_q[$];
  logic [11:0] exp_wr[$];
  logic [15:0] exp_ev[$];

  uart_cmd_ctrl #(.TIMEOUT_CLKS(16'd20), .MAX_LEN(5'd16)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
    .o_Cmd_Valid(cmd_valid), .o_Cmd(cmd), .o_Cmd_Len(cmd_len),
    .o_Err(err), .o_Err_Code(err_code), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (cmd_valid) ev_q.push_back({3'b001, cmd_len, cmd});
    if (err) ev_q.push_back({3'b010, 11'd0, err_code});
    if (cmd_valid && err) both_cnt++;
  end

  function automatic logic [15:0] ok_ev(input logic [7:0] c, input logic [4:0] l);
    return {3'b001, l, c};
  endfunction

  function automatic logic [15:0] err_ev(input logic [1:0] code);
    return {3'b010, 11'd0, code};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    rx_byte = $urandom_range(255, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bq_t s, input int maxgap);
    foreach (s[i]) begin
      send_byte(s[i]);
      idle($urandom_range(maxgap, 0));
    end
    idle(4);
  endtask

  task automatic flush();
    wr_q.delete();
    ev_q.delete();
  endtask

  // Reference: scan the byte stream frame by frame with plain arithmetic
  task automatic model(input bq_t s);
    int i, len;
    logic [7:0] sum;
    exp_wr.delete();
    exp_ev.delete();
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      len = s[i+2];
      if (len > 16) begin
        exp_ev.push_back(err_ev(2'd1));
        i += 3;
        continue;
      end
      sum = s[i+1] + s[i+2];
      for (int k = 0; k < len; k++) begin
        exp_wr.push_back({k[3:0], s[i+3+k]});
        sum += s[i+3+k];
      end
      exp_ev.push_back(s[i+3+len] == sum ? ok_ev(s[i+1], len[4:0]) : err_ev(2'd3));
      i += 4 + len;
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, err, err_code} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got wr=%b addr=%h data=%h cv=%b cmd=%h len=%0d err=%b code=%0d, want all 0",
               wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, err, err_code);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_frame();
    flush();
    drive('{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89}, 2);
    tests++;
    if (wr_q.size() != 2 || wr_q[0] !== 12'h033 || wr_q[1] !== 12'h144) begin
      fails++; $display("FAIL good_writes: got %p want '{033,144}", wr_q);
    end
    tests++;
    if (ev_q.size() != 1 || ev_q[0] !== ok_ev(8'h10, 5'd2)) begin
      fails++; $display("FAIL good_commit: got %p want %h", ev_q, ok_ev(8'h10, 5'd2));
    end
    tests++;
    if (cmd !== 8'h10 || cmd_len !== 5'd2) begin
      fails++; $display("FAIL good_hold: got cmd=%h len=%0d want 10/2", cmd, cmd_len);
    end
  endtask

  task automatic test_zero_len();
    flush();
    drive('{8'hA5, 8'h20, 8'h00, 8'h20}, 1);
    tests++;
    if (wr_q.size() != 0) begin fails++; $display("FAIL zero_writes: got %0d want 0", wr_q.size()); end
    tests++;
    if (ev_q.size() != 1 || ev_q[0] !== ok_ev(8'h20, 5'd0)) begin
      fails++; $display("FAIL zero_commit: got %p want %h", ev_q, ok_ev(8'h20, 5'd0));
    end
  endtask

  task automatic test_csum_err();
    flush();
    drive('{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00, 8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h89}, 0);
    tests++;
    if (wr_q.size() != 3 || wr_q[0] !== 12'h055) begin
      fails++; $display("FAIL csum_writes: got %p want first 055 of 3", wr_q);
    end
    tests++;
    if (ev_q.size() != 2 || ev_q[0] !== err_ev(2'd3) || ev_q[1] !== ok_ev(8'h10, 5'd2)) begin
      fails++; $display("FAIL csum_events: got %p want '{%h,%h}", ev_q, err_ev(2'd3), ok_ev(8'h10, 5'd2));
    end
  endtask

  task automatic test_len_err_noise();
    flush();
    drive('{8'h12, 8'h34, 8'hA5, 8'h01, 8'h11, 8'hA5, 8'h01, 8'h01, 8'hAA, 8'hAC}, 1);
    tests++;
    if (ev_q.size() != 2 || ev_q[0] !== err_ev(2'd1) || ev_q[1] !== ok_ev(8'h01, 5'd1)) begin
      fails++; $display("FAIL len_events: got %p want '{%h,%h}", ev_q, err_ev(2'd1), ok_ev(8'h01, 5'd1));
    end
    tests++;
    if (wr_q.size() != 1 || wr_q[0] !== 12'h0AA) begin
      fails++; $display("FAIL len_writes: got %p want '{0AA}", wr_q);
    end
  endtask

  task automatic test_timeout();
    flush();
    send_byte(8'hA5);
    send_byte(8'h07);
    idle(19);
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL timeout_early: got err=%b busy=%b want 0/1", err, busy);
    end
    idle(1);
    tests++;
    if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      fails++; $display("FAIL timeout_fire: got err=%b code=%0d busy=%b want 1/2/0", err, err_code, busy);
    end
    idle(10);
    tests++;
    if (ev_q.size() != 1 || ev_q[0] !== err_ev(2'd2)) begin
      fails++; $display("FAIL timeout_events: got %p want %h", ev_q, err_ev(2'd2));
    end
    flush();
    send_byte(8'hA5);
    send_byte(8'h07);
    idle(19);
    send_byte(8'h00);
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL timeout_byte_wins: got err=%b busy=%b want 0/1", err, busy);
    end
    send_byte(8'h07);
    idle(3);
    tests++;
    if (ev_q.size() != 1 || ev_q[0] !== ok_ev(8'h07, 5'd0)) begin
      fails++; $display("FAIL timeout_edge_commit: got %p want %h", ev_q, ok_ev(8'h07, 5'd0));
    end
  endtask

  task automatic test_reset_mid_data();
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h03);
    send_byte(8'h5A);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, err, err_code, busy} !== '0) begin
      fails++;
      $display("FAIL mid_reset: got wr=%b addr=%h data=%h cv=%b cmd=%h len=%0d err=%b code=%0d busy=%b, want all 0",
               wr_en, wr_addr, wr_data, cmd_valid, cmd, cmd_len, err, err_code, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    drive('{8'h11, 8'hA5, 8'h11, 8'h01, 8'h66, 8'h78}, 1);
    tests++;
    if (ev_q.size() != 1 || ev_q[0] !== ok_ev(8'h11, 5'd1) || wr_q.size() != 1 || wr_q[0] !== 12'h066) begin
      fails++; $display("FAIL mid_reset_recover: got ev=%p wr=%p want %h / 066", ev_q, wr_q, ok_ev(8'h11, 5'd1));
    end
  endtask

  task automatic test_random(input int frames, input int maxgap);
    bq_t s;
    int kind, len;
    logic [7:0] sum, b;
    for (int f = 0; f < frames; f++) begin
      kind = $urandom_range(3, 0);
      if (kind == 0) begin
        b = $urandom_range(255, 0);
        s.push_back(b == 8'hA5 ? 8'h5A : b);
        continue;
      end
      len = (kind == 1) ? $urandom_range(255, 17) : $urandom_range(16, 0);
      s.push_back(8'hA5);
      b = $urandom_range(255, 0);
      s.push_back(b);
      s.push_back(len[7:0]);
      if (kind == 1) continue;
      sum = b + len[7:0];
      for (int k = 0; k < len; k++) begin
        b = $urandom_range(255, 0);
        s.push_back(b);
        sum += b;
      end
      s.push_back(kind == 3 ? sum ^ 8'($urandom_range(255, 1)) : sum);
    end
    model(s);
    flush();
    drive(s, maxgap);
    tests++;
    if (wr_q.size() != exp_wr.size()) begin
      fails++; $display("FAIL rand_wr_count: got %0d want %0d", wr_q.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        tests++;
        if (wr_q[i] !== exp_wr[i]) begin
          fails++; $display("FAIL rand_wr[%0d]: got %h want %h", i, wr_q[i], exp_wr[i]);
        end
      end
    end
    tests++;
    if (ev_q.size() != exp_ev.size()) begin
      fails++; $display("FAIL rand_ev_count: got %0d want %0d", ev_q.size(), exp_ev.size());
    end else begin
      foreach (exp_ev[i]) begin
        tests++;
        if (ev_q[i] !== exp_ev[i]) begin
          fails++; $display("FAIL rand_ev[%0d]: got %h want %h", i, ev_q[i], exp_ev[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_zero_len();
    test_csum_err();
    test_len_err_noise();
    test_timeout();
    test_reset_mid_data();
    test_random(12, 3);
    test_random(12, 0);
    test_random(20, 5);
    tests++;
    if (both_cnt != 0) begin fails++; $display("FAIL valid_err_overlap: got %0d cycles want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
